// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the RV32I pipeline.
//
// Holds the fetch PC and chooses the next PC from the execute redirect, a stall,
// or a BTB-backed prediction. Without any of these the next PC is pc+4. It also
// fills the IF/ID pipeline register that decode reads.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall_ip            hold PC and IF/ID
//   redirect_ip         refetch from redirect_pc_ip and flush IF/ID (overrides stall)
//   redirect_pc_ip      corrected next PC (word aligned on load)
//   ex_update_ip        resolved branch in execute this cycle
//   ex_pc_ip            PC of the resolved branch
//   ex_taken_ip         actual direction
//   ex_target_ip        actual target
//   prediction_ip       2-bit predictor direction for if_pc_op (same cycle)
//   imem_rdata_ip       instruction word at imem_addr_op (combinational read)
//   if_pc_op            current fetch PC
//   imem_addr_op        same as if_pc_op
//   id_valid_op         IF/ID holds a valid instruction
//   id_pc_op            IF/ID instruction PC
//   id_instr_op         IF/ID instruction word
//   id_pred_taken_op    fetch predicted taken
//   id_pred_target_op   next PC chosen by fetch
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_ip,
  input  logic        redirect_ip,
  input  logic [31:0] redirect_pc_ip,
  input  logic        ex_update_ip,
  input  logic [31:0] ex_pc_ip,
  input  logic        ex_taken_ip,
  input  logic [31:0] ex_target_ip,
  input  logic        prediction_ip,
  input  logic [31:0] imem_rdata_ip,
  output logic [31:0] if_pc_op,
  output logic [31:0] imem_addr_op,
  output logic        id_valid_op,
  output logic [31:0] id_pc_op,
  output logic [31:0] id_instr_op,
  output logic        id_pred_taken_op,
  output logic [31:0] id_pred_target_op
);

  localparam int TAG_W   = 32 - BTB_IDX_W - 2;
  localparam int N_ENTRY = 1 << BTB_IDX_W;

  logic [31:0]          pc;
  logic [N_ENTRY-1:0]   btb_valid;
  logic [TAG_W-1:0]     btb_tag [N_ENTRY];
  logic [29:0]          btb_tgt [N_ENTRY];

  logic [BTB_IDX_W-1:0] rd_idx;
  logic [BTB_IDX_W-1:0] wr_idx;
  logic                 hit;
  logic                 pred_hit;
  logic [31:0]          seq_pc;
  logic [31:0]          next_pc;
  logic                 btb_wr;

  assign if_pc_op     = pc;
  assign imem_addr_op = pc;

  // Lookup reads the registered arrays, so a same-cycle update is not seen
  // until the following cycle.
  assign rd_idx   = pc[BTB_IDX_W+1:2];
  assign hit      = btb_valid[rd_idx] && (btb_tag[rd_idx] == pc[31:BTB_IDX_W+2]);
  assign pred_hit = prediction_ip && hit;
  assign seq_pc   = pc + 32'd4;
  assign next_pc  = pred_hit ? {btb_tgt[rd_idx], 2'b00} : seq_pc;

  assign wr_idx = ex_pc_ip[BTB_IDX_W+1:2];
  assign btb_wr = ex_update_ip && ex_taken_ip;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= RESET_PC;
      id_valid_op       <= 1'b0;
      id_pc_op          <= 32'h0;
      id_instr_op       <= 32'h0;
      id_pred_taken_op  <= 1'b0;
      id_pred_target_op <= 32'h0;
    end else if (redirect_ip) begin
      pc          <= {redirect_pc_ip[31:2], 2'b00};
      id_valid_op <= 1'b0;
    end else if (!stall_ip) begin
      pc                <= next_pc;
      id_valid_op       <= 1'b1;
      id_pc_op          <= pc;
      id_instr_op       <= imem_rdata_ip;
      id_pred_taken_op  <= pred_hit;
      id_pred_target_op <= next_pc;
    end
  end

  // Only the valid bits need reset; tag/target are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (btb_wr) begin
      btb_valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && btb_wr) begin
      btb_tag[wr_idx] <= ex_pc_ip[31:BTB_IDX_W+2];
      btb_tgt[wr_idx] <= ex_target_ip[31:2];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, BTB hit/miss,
// redirect/stall priority, PC wrap and reset during activity.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_ip;
  logic        redirect_ip;
  logic [31:0] redirect_pc_ip;
  logic        ex_update_ip;
  logic [31:0] ex_pc_ip;
  logic        ex_taken_ip;
  logic [31:0] ex_target_ip;
  logic        prediction_ip;
  logic [31:0] imem_rdata_ip;
  logic [31:0] if_pc_op;
  logic [31:0] imem_addr_op;
  logic        id_valid_op;
  logic [31:0] id_pc_op;
  logic [31:0] id_instr_op;
  logic        id_pred_taken_op;
  logic [31:0] id_pred_target_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word = address ^ K.
  assign imem_rdata_ip = imem_addr_op ^ K;

  fetch_unit #(.RESET_PC(32'h0), .BTB_IDX_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_ip          (stall_ip),
    .redirect_ip       (redirect_ip),
    .redirect_pc_ip    (redirect_pc_ip),
    .ex_update_ip      (ex_update_ip),
    .ex_pc_ip          (ex_pc_ip),
    .ex_taken_ip       (ex_taken_ip),
    .ex_target_ip      (ex_target_ip),
    .prediction_ip     (prediction_ip),
    .imem_rdata_ip     (imem_rdata_ip),
    .if_pc_op          (if_pc_op),
    .imem_addr_op      (imem_addr_op),
    .id_valid_op       (id_valid_op),
    .id_pc_op          (id_pc_op),
    .id_instr_op       (id_instr_op),
    .id_pred_taken_op  (id_pred_taken_op),
    .id_pred_target_op (id_pred_target_op)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_ip    = 1'b1;
    redirect_pc_ip = target;
    step();
    redirect_ip    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall_ip = 1'b0; redirect_ip = 1'b0; redirect_pc_ip = 32'h0;
    ex_update_ip = 1'b0; ex_pc_ip = 32'h0; ex_taken_ip = 1'b0; ex_target_ip = 32'h0;
    prediction_ip = 1'b0;

    // Reset for two cycles
    step();
    step();
    chk("rst_pc", if_pc_op, 32'h0);
    chk("rst_valid", {31'h0, id_valid_op}, 32'h0);
    chk("rst_idpc", id_pc_op, 32'h0);
    chk("rst_tgt", id_pred_target_op, 32'h0);
    chk("imem_addr", imem_addr_op, 32'h0);

    // Sequential fetch 0,4,8,C
    rst = 1'b0;
    step();
    chk("seq_pc4", if_pc_op, 32'h4);
    chk("seq_valid", {31'h0, id_valid_op}, 32'h1);
    chk("seq_idpc0", id_pc_op, 32'h0);
    chk("seq_instr0", id_instr_op, 32'h0 ^ K);
    chk("seq_tgt0", id_pred_target_op, 32'h4);
    step();
    chk("seq_pc8", if_pc_op, 32'h8);
    step();
    chk("seq_pcC", if_pc_op, 32'hC);
    chk("seq_idpc8", id_pc_op, 32'h8);

    // Install BTB 0x10 -> 0x40 while fetching 0xC
    ex_update_ip = 1'b1; ex_taken_ip = 1'b1; ex_pc_ip = 32'h10; ex_target_ip = 32'h40;
    step();
    ex_update_ip = 1'b0; ex_taken_ip = 1'b0;
    chk("inst_pc10", if_pc_op, 32'h10);
    prediction_ip = 1'b1;
    step();
    chk("hit_pc", if_pc_op, 32'h40);
    chk("hit_idpc", id_pc_op, 32'h10);
    chk("hit_taken", {31'h0, id_pred_taken_op}, 32'h1);
    chk("hit_tgt", id_pred_target_op, 32'h40);
    chk("hit_instr", id_instr_op, 32'h10 ^ K);

    // Same PC, predictor not taken
    do_redirect(32'h10);
    chk("redir_pc10", if_pc_op, 32'h10);
    chk("redir_flush", {31'h0, id_valid_op}, 32'h0);
    prediction_ip = 1'b0;
    step();
    chk("nt_pc", if_pc_op, 32'h14);
    chk("nt_taken", {31'h0, id_pred_taken_op}, 32'h0);
    chk("nt_tgt", id_pred_target_op, 32'h14);
    chk("nt_valid", {31'h0, id_valid_op}, 32'h1);

    // Tag mismatch at 0x50 (same index as 0x10)
    do_redirect(32'h50);
    prediction_ip = 1'b1;
    step();
    chk("tagmiss_pc", if_pc_op, 32'h54);
    chk("tagmiss_taken", {31'h0, id_pred_taken_op}, 32'h0);

    // Same-cycle update and lookup at 0x20: lookup sees the old (empty) entry
    do_redirect(32'h20);
    ex_update_ip = 1'b1; ex_taken_ip = 1'b1; ex_pc_ip = 32'h20; ex_target_ip = 32'h80;
    prediction_ip = 1'b1;
    step();
    ex_update_ip = 1'b0; ex_taken_ip = 1'b0;
    chk("nobypass_pc", if_pc_op, 32'h24);
    chk("nobypass_taken", {31'h0, id_pred_taken_op}, 32'h0);
    do_redirect(32'h20);
    step();
    chk("later_hit_pc", if_pc_op, 32'h80);

    // Not-taken resolution leaves the 0x10 entry unchanged
    ex_update_ip = 1'b1; ex_taken_ip = 1'b0; ex_pc_ip = 32'h10; ex_target_ip = 32'h200;
    do_redirect(32'h10);
    ex_update_ip = 1'b0;
    step();
    chk("nt_upd_pc", if_pc_op, 32'h40);

    // Redirect during stall: redirect wins, address aligned
    prediction_ip = 1'b0;
    stall_ip = 1'b1;
    do_redirect(32'h103);
    chk("stredir_pc", if_pc_op, 32'h100);
    chk("stredir_valid", {31'h0, id_valid_op}, 32'h0);
    stall_ip = 1'b0;
    step();
    chk("post_pc", if_pc_op, 32'h104);
    chk("post_idpc", id_pc_op, 32'h100);

    // Stall alone for three cycles: everything holds
    stall_ip = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", if_pc_op, 32'h104);
      chk("stall_idpc", id_pc_op, 32'h100);
      chk("stall_instr", id_instr_op, 32'h100 ^ K);
      chk("stall_valid", {31'h0, id_valid_op}, 32'h1);
    end
    stall_ip = 1'b0;

    // PC wrap-around
    do_redirect(32'hFFFF_FFFC);
    chk("wrap_pre", if_pc_op, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", if_pc_op, 32'h0);
    chk("wrap_idpc", id_pc_op, 32'hFFFF_FFFC);
    chk("wrap_tgt", id_pred_target_op, 32'h0);

    // Install 0x30 -> 0x90, then reset with redirect and another update
    ex_update_ip = 1'b1; ex_taken_ip = 1'b1; ex_pc_ip = 32'h30; ex_target_ip = 32'h90;
    step();
    rst = 1'b1;
    redirect_ip = 1'b1; redirect_pc_ip = 32'h500;
    ex_pc_ip = 32'h34; ex_target_ip = 32'hA0;
    step();
    rst = 1'b0; redirect_ip = 1'b0; ex_update_ip = 1'b0; ex_taken_ip = 1'b0;
    chk("mrst_pc", if_pc_op, 32'h0);
    chk("mrst_valid", {31'h0, id_valid_op}, 32'h0);
    chk("mrst_idpc", id_pc_op, 32'h0);
    do_redirect(32'h30);
    prediction_ip = 1'b1;
    step();
    chk("mrst_miss30", if_pc_op, 32'h34);
    chk("mrst_taken", {31'h0, id_pred_taken_op}, 32'h0);
    step();
    chk("mrst_miss34", if_pc_op, 32'h38);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
